// File: rtl/elevator_car_controller.sv
// Per-car SCAN controller: latches hall/car calls, moves one floor per travel
// period, opens doors at requested floors and reports a 2-bit car state.
module elevator_car_controller #(
  parameter int unsigned FLOORS       = 6,
  parameter int unsigned FLOOR_W      = 3,
  parameter int unsigned TRAVEL_TICKS = 750,
  parameter int unsigned DOOR_TICKS   = 1500,
  parameter int unsigned TMR_W        = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         sim_state,
  input  logic [2:0]         sim_speed,
  input  logic [FLOORS-1:0]  floors_requested,
  input  logic [FLOORS-1:0]  floor_destinations,
  output logic [1:0]         car_state,
  output logic [FLOOR_W-1:0] car_floor,
  output logic [FLOORS-1:0]  served
);

  localparam logic [TMR_W-1:0] TRAVEL_LIM = TMR_W'(TRAVEL_TICKS);
  localparam logic [TMR_W-1:0] DOOR_LIM   = TMR_W'(DOOR_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_UP    = 2'b01,
    ST_DOWN  = 2'b10,
    ST_DOORS = 2'b11
  } state_t;

  state_t             state, state_n;
  logic               dir_up, dir_up_n;
  logic [TMR_W-1:0]   timer, timer_n, timer_inc;
  logic [FLOOR_W-1:0] floor_n, eval_floor;
  logic [FLOORS-1:0]  pending, pending_n, served_n;
  logic               clear, paused, expire, eval, prefer_up, above, below;

  function automatic logic req_above(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++)
      if (FLOOR_W'(i) > f) r = r | p[i];
    return r;
  endfunction

  function automatic logic req_below(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++)
      if (FLOOR_W'(i) < f) r = r | p[i];
    return r;
  endfunction

  assign clear  = (sim_state == 2'b00);
  assign paused = sim_state[1];

  // State register; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      dir_up    <= 1'b1;
      timer     <= '0;
      car_floor <= '0;
      pending   <= '0;
      served    <= '0;
    end else begin
      state     <= state_n;
      dir_up    <= dir_up_n;
      timer     <= timer_n;
      car_floor <= floor_n;
      pending   <= pending_n;
      served    <= served_n;
    end
  end

  assign car_state = state;

  // Next state: timer advance, arrival handling and the SCAN decision.
  always_comb begin
    state_n    = state;
    dir_up_n   = dir_up;
    timer_n    = timer;
    floor_n    = car_floor;
    served_n   = '0;
    pending_n  = pending | floors_requested | floor_destinations;
    timer_inc  = timer + TMR_W'(sim_speed);
    expire     = 1'b0;
    eval       = 1'b0;
    eval_floor = car_floor;
    prefer_up  = dir_up;
    above      = 1'b0;
    below      = 1'b0;

    if (clear) begin
      state_n   = ST_IDLE;
      dir_up_n  = 1'b1;
      timer_n   = '0;
      floor_n   = '0;
      pending_n = '0;
    end else if (!paused) begin
      case (state)
        ST_IDLE: begin
          eval      = 1'b1;
          prefer_up = 1'b1;
        end
        ST_UP, ST_DOWN: begin
          expire = (timer_inc >= TRAVEL_LIM);
          if (expire) begin
            eval       = 1'b1;
            eval_floor = (state == ST_UP) ? car_floor + FLOOR_W'(1)
                                          : car_floor - FLOOR_W'(1);
            floor_n    = eval_floor;
          end else begin
            timer_n = timer_inc;
          end
        end
        ST_DOORS: begin
          expire = (timer_inc >= DOOR_LIM);
          // A fresh call for this floor keeps the doors open and re-announces it.
          if (pending[car_floor]) begin
            served_n             = FLOORS'(1) << car_floor;
            pending_n[car_floor] = 1'b0;
            timer_n              = '0;
          end else if (expire) begin
            eval = 1'b1;
          end else begin
            timer_n = timer_inc;
          end
        end
        default: ;
      endcase

      above = req_above(pending, eval_floor);
      below = req_below(pending, eval_floor);

      if (eval) begin
        timer_n = '0;
        if (pending[eval_floor]) begin
          state_n               = ST_DOORS;
          served_n              = FLOORS'(1) << eval_floor;
          pending_n[eval_floor] = 1'b0;
        end else if ((prefer_up && above) || (!prefer_up && !below && above)) begin
          state_n  = ST_UP;
          dir_up_n = 1'b1;
        end else if (below) begin
          state_n  = ST_DOWN;
          dir_up_n = 1'b0;
        end else begin
          state_n = ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_elevator_car_controller.sv
// Bench for elevator_car_controller: directed scenarios plus random traffic,
// all checked every cycle against a behavioural car model.
module tb_elevator_car_controller;

  localparam int FLOORS  = 6;
  localparam int FLOOR_W = 3;
  localparam int TRAVEL  = 8;
  localparam int DOOR    = 12;
  localparam int TMR_W   = 12;

  localparam int M_IDLE  = 0;
  localparam int M_UP    = 1;
  localparam int M_DOWN  = 2;
  localparam int M_DOORS = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [1:0]         sim_state = 2'b01;
  logic [2:0]         sim_speed = 3'd1;
  logic [FLOORS-1:0]  floors_requested = '0;
  logic [FLOORS-1:0]  floor_destinations = '0;
  logic [1:0]         car_state;
  logic [FLOOR_W-1:0] car_floor;
  logic [FLOORS-1:0]  served;

  int n_checks = 0;
  int n_fail   = 0;
  int srv_log[$];

  // Model of the car: mode, floor, travel/door progress, heading and calls.
  int m_mode, m_floor, m_timer, m_srv;
  bit m_up;
  bit m_pend[FLOORS];
  bit nxt[FLOORS];

  always #5 clk = ~clk;

  elevator_car_controller #(
    .FLOORS(FLOORS), .FLOOR_W(FLOOR_W), .TRAVEL_TICKS(TRAVEL),
    .DOOR_TICKS(DOOR), .TMR_W(TMR_W)
  ) dut (
    .clk(clk), .rst(rst), .sim_state(sim_state), .sim_speed(sim_speed),
    .floors_requested(floors_requested), .floor_destinations(floor_destinations),
    .car_state(car_state), .car_floor(car_floor), .served(served)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit req_beyond(input int f, input bit up);
    for (int i = 0; i < FLOORS; i++)
      if (m_pend[i] && (up ? (i > f) : (i < f))) return 1'b1;
    return 1'b0;
  endfunction

  // Car stands at floor f and chooses what to do next.
  task automatic settle(input int f, input bit from_idle);
    bit want_up;
    m_floor = f;
    m_timer = 0;
    if (m_pend[f]) begin
      m_mode = M_DOORS;
      m_srv  = f;
      nxt[f] = 1'b0;
    end else begin
      want_up = from_idle ? 1'b1 : m_up;
      if (req_beyond(f, want_up)) m_up = want_up;
      else if (req_beyond(f, !want_up)) m_up = !want_up;
      else begin
        m_mode = M_IDLE;
        return;
      end
      m_mode = m_up ? M_UP : M_DOWN;
    end
  endtask

  task automatic model_step(input bit r, input bit [1:0] ss, input int sp,
                            input bit [5:0] hr, input bit [5:0] cr);
    m_srv = -1;
    if (r || ss == 2'b00) begin
      m_mode = M_IDLE; m_floor = 0; m_timer = 0; m_up = 1'b1;
      for (int i = 0; i < FLOORS; i++) m_pend[i] = 1'b0;
      return;
    end
    for (int i = 0; i < FLOORS; i++) nxt[i] = m_pend[i] | hr[i] | cr[i];
    if (!ss[1]) begin
      case (m_mode)
        M_IDLE: settle(m_floor, 1'b1);
        M_UP, M_DOWN:
          if (m_timer + sp >= TRAVEL) settle((m_mode == M_UP) ? m_floor + 1 : m_floor - 1, 1'b0);
          else m_timer += sp;
        default:
          if (m_pend[m_floor]) begin
            m_srv = m_floor;
            nxt[m_floor] = 1'b0;
            m_timer = 0;
          end else if (m_timer + sp >= DOOR) settle(m_floor, 1'b0);
          else m_timer += sp;
      endcase
    end
    for (int i = 0; i < FLOORS; i++) m_pend[i] = nxt[i];
  endtask

  // One clock: drive inputs, advance model, compare all outputs.
  task automatic tick(input bit r, input bit [1:0] ss, input int sp,
                      input bit [5:0] hr, input bit [5:0] cr);
    int exp_srv;
    @(negedge clk);
    rst = r; sim_state = ss; sim_speed = 3'(sp);
    floors_requested = hr; floor_destinations = cr;
    @(posedge clk);
    #1;
    model_step(r, ss, sp, hr, cr);
    exp_srv = (m_srv < 0) ? 0 : (1 << m_srv);
    check_eq("car_state", int'(car_state), m_mode);
    check_eq("car_floor", int'(car_floor), m_floor);
    check_eq("served", int'(served), exp_srv);
    for (int i = 0; i < FLOORS; i++) if (served[i]) srv_log.push_back(i);
  endtask

  task automatic run(input int n, input int sp);
    repeat (n) tick(1'b0, 2'b01, sp, 6'b0, 6'b0);
  endtask

  initial begin
    int cnt;
    bit found;
    bit [5:0] hr, cr;
    bit [1:0] ss;
    int sp, v;

    // Reset, then a car call at floor 0
    tick(1'b1, 2'b01, 1, 6'b0, 6'b0);
    check_eq("rst_state", int'(car_state), 0);
    check_eq("rst_floor", int'(car_floor), 0);
    check_eq("rst_served", int'(served), 0);
    tick(1'b0, 2'b01, 1, 6'b0, 6'b000001);
    check_eq("t1_latency", int'(car_state), 0);
    run(1, 1);
    check_eq("t1_doors", int'(car_state), 3);
    check_eq("t1_served", int'(served), 1);
    run(11, 1);
    check_eq("t1_still_open", int'(car_state), 3);
    run(1, 1);
    check_eq("t1_closed", int'(car_state), 0);

    // Hall call at floor 3: one floor per 8 cycles
    tick(1'b0, 2'b01, 1, 6'b001000, 6'b0);
    run(1, 1);
    check_eq("t2_up", int'(car_state), 1);
    for (int k = 1; k <= 24; k++) begin
      run(1, 1);
      if (k == 8)  check_eq("t2_floor1", int'(car_floor), 1);
      if (k == 16) check_eq("t2_floor2", int'(car_floor), 2);
      if (k == 24) begin
        check_eq("t2_floor3", int'(car_floor), 3);
        check_eq("t2_doors", int'(car_state), 3);
        check_eq("t2_served", int'(served), 8);
      end
    end
    run(12, 1);
    check_eq("t2_idle", int'(car_state), 0);

    // Calls above and below: serve 5 first, then reverse to 1
    srv_log.delete();
    tick(1'b0, 2'b01, 1, 6'b100000, 6'b000010);
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      run(1, 1);
      if (car_state == 2'b00 && car_floor == 3'd1 && srv_log.size() == 2) found = 1'b1;
    end
    check_eq("t3_done", int'(found), 1);
    check_eq("t3_count", srv_log.size(), 2);
    check_eq("t3_first", (srv_log.size() > 0) ? srv_log[0] : -1, 5);
    check_eq("t3_second", (srv_log.size() > 1) ? srv_log[1] : -1, 1);

    // Pause mid-travel for 50 cycles
    tick(1'b0, 2'b01, 1, 6'b001000, 6'b0);
    run(1, 1);
    check_eq("t4_up", int'(car_state), 1);
    cnt = 0;
    repeat (3) begin run(1, 1); cnt++; end
    for (int k = 0; k < 50; k++) begin
      tick(1'b0, (k % 2 == 0) ? 2'b10 : 2'b11, 1, 6'b0, 6'b0);
      cnt++;
    end
    check_eq("t4_frozen_floor", int'(car_floor), 1);
    check_eq("t4_frozen_state", int'(car_state), 1);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      run(1, 1); cnt++;
      if (car_floor == 3'd2) found = 1'b1;
    end
    check_eq("t4_arrival_cycles", found ? cnt : -1, 58);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      run(1, 1);
      if (car_state == 2'b00) found = 1'b1;
    end
    check_eq("t4_idle", int'(found), 1);

    // Speed 4 travel and doors
    tick(1'b0, 2'b01, 4, 6'b100000, 6'b0);
    run(1, 4);
    cnt = 0; found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      run(1, 4); cnt++;
      if (car_floor == 3'd4) found = 1'b1;
    end
    check_eq("t5_fast_floor", found ? cnt : -1, 2);
    cnt = 0; found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      run(1, 4); cnt++;
      if (car_state == 2'b11) found = 1'b1;
    end
    check_eq("t5_fast_arrive", found ? cnt : -1, 2);
    cnt = 0; found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      run(1, 4); cnt++;
      if (car_state == 2'b00) found = 1'b1;
    end
    check_eq("t5_fast_doors", found ? cnt : -1, 3);

    // Speed 0 while travelling: frozen
    tick(1'b0, 2'b01, 0, 6'b000100, 6'b010000);
    run(1, 0);
    check_eq("t5_down", int'(car_state), 2);
    run(100, 0);
    check_eq("t5_stuck_floor", int'(car_floor), 5);
    check_eq("t5_stuck_state", int'(car_state), 2);

    // Reset while doors open at floor 4 with floor 2 still pending
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      run(1, 1);
      if (car_state == 2'b11 && car_floor == 3'd4) found = 1'b1;
    end
    check_eq("t6_at4", int'(found), 1);
    tick(1'b1, 2'b01, 1, 6'b0, 6'b0);
    check_eq("t6_state", int'(car_state), 0);
    check_eq("t6_floor", int'(car_floor), 0);
    check_eq("t6_served", int'(served), 0);
    run(5, 1);
    check_eq("t6_no_pending", int'(car_state), 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      v  = $urandom_range(0, 99);
      ss = (v < 2) ? 2'b00 : (v < 10) ? 2'($urandom_range(2, 3)) : 2'b01;
      sp = ($urandom_range(0, 9) > 7) ? 0 : $urandom_range(1, 7);
      hr = '0;
      cr = '0;
      for (int i = 0; i < FLOORS; i++) begin
        if ($urandom_range(0, 19) == 0) hr[i] = 1'b1;
        if ($urandom_range(0, 19) == 0) cr[i] = 1'b1;
      end
      tick(($urandom_range(0, 499) == 0), ss, sp, hr, cr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
